multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle ARM-style core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALUOp code into ALUControl, plus the mux selects and write enables for the PC, IR, register file and unified memory port.
- Handles variable-latency memory with a req/ready handshake and an optional wait-state timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles `mem_req` stays high without `mem_ready`. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  IR contents; valid from the cycle after `ir_write`
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write (only with `mem_req`)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted branch offset
- ALUOp  out  2  to ALUControl: 00 = add, 01 = compare, 10 = use instruction[27:25]
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- illegal  out  1  one-cycle pulse: undefined condition field
- bus_err  out  1  one-cycle pulse: memory timeout
- instr_count  out  32  instructions retired, wraps modulo 2^32
- state  out  4  current state, debug only

Behaviour:
- Reset:
  - `rst_n` low asynchronously forces state IDLE, clears the wait counter and `instr_count`.
  - All outputs are 0 while in reset and in IDLE.
  - IDLE always goes to FETCH on the next clock.
- Control outputs are Moore decodes of the state. Exceptions, which are Mealy-gated: `ir_write`/`pc_write` in FETCH on `mem_ready`, and `pc_write` in BRANCH on `alu_zero`.
- Opcode field is instruction[27:25]:
  - 000 ADD, 010 SUB, 100 AND, 101 ORR: R-type.
  - 001 LDR, 011 STR.
  - 110 BEQ, 111 B.
- FETCH:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `ALUOp`=00, `pc_src`=00.
  - Holds until `mem_ready`. In the `mem_ready` cycle `ir_write`=1 and `pc_write`=1, then goes to DECODE.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `ALUOp`=00 (branch target into ALUOut).
  - instruction[31:28]==4'hF: `illegal` pulses, go to FETCH, no retire.
  - Otherwise dispatch: R-type -> EXEC_R; LDR/STR -> MEM_ADDR; BEQ -> BRANCH; B -> JUMP.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `ALUOp`=10 -> ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0 -> FETCH, retire.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALUOp`=00. LDR -> MEM_RD; STR -> MEM_WR.
- MEM_RD: `mem_req`=1, `iord`=1, hold until `mem_ready` -> MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1 -> FETCH, retire.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1, hold until `mem_ready` -> FETCH, retire.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `ALUOp`=01, `pc_src`=01, `pc_write`=`alu_zero` -> FETCH, retire.
- JUMP: `pc_src`=10, `pc_write`=1 -> FETCH, retire.
- Handshake:
  - `mem_req`, `mem_we` and `iord` stay stable until `mem_ready` is sampled high.
  - `mem_ready` in the first request cycle completes with zero wait states.
  - `mem_ready` outside a memory state is ignored.
- Timeout:
  - The wait counter clears on entering any memory state and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When the count reaches TIMEOUT_CYCLES (nonzero): `bus_err` pulses, `mem_req` drops that cycle, and state goes to FETCH.
  - No IR, PC or register write occurs. A timed-out FETCH retries the same PC.
  - `mem_ready` in the same cycle as the timeout wins: completion, no error.
- Retire: `instr_count`+1 on the clock edge leaving ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP.
- Instruction latency with zero-wait memory:
  - R-type 4 cycles, LDR 5, STR 4, BEQ 3, B 3.

Decomposition:
- Shared package `cpu_ctrl_pkg` holds:
  - State encodings: 4-bit localparams, IDLE=0 .. JUMP=10.
  - Opcode constants.
  - `ALUOp` codes 00/01/10.
  - `pc_src` and `alu_src_b` select codes.
  - The undefined-condition constant 4'hF.
- One natural sub-module: `mem_wait_timer`, the wait counter plus timeout compare.

Test Plan:
- Reset: `rst_n`=0 mid-MEM_RD -> `state`=0, all outputs 0. First post-reset cycle IDLE, second FETCH with `mem_req`=1.
- ADD, zero wait states: instruction=32'hE000_0000 -> FETCH, DECODE, EXEC_R (`ALUOp`=10), ALU_WB (`reg_write`=1). `instr_count` 0 -> 1 after 4 cycles.
- LDR with 3 wait states: opcode 001 -> MEM_RD holds `mem_req`/`iord`=1 for 4 cycles. MEM_WB `mem_to_reg`=1, total 8 cycles.
- BEQ: `alu_zero`=1 -> `pc_write`=1 with `pc_src`=01. `alu_zero`=0 -> `pc_write`=0. Both retire.
- Illegal: instruction=32'hF000_0000 -> `illegal` pulses in DECODE, next state FETCH, `instr_count` unchanged.
- Timeout: TIMEOUT_CYCLES=4, `mem_ready` held 0 in FETCH -> `bus_err` pulse on the 5th request cycle, `ir_write` never 1, FETCH re-entered. Repeat with `mem_ready`=1 exactly at the timeout cycle -> no `bus_err`.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle core control path.
// Holds the state encoding, opcode field values, ALUOp and mux select codes,
// the undefined condition value, and the Moore output decode used by the FSM.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_ALU_WB   = 4'd4,
      ST_MEM_ADDR = 4'd5,
      ST_MEM_RD   = 4'd6,
      ST_MEM_WB   = 4'd7,
      ST_MEM_WR   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10
   } state_e;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LDR = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_STR = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_ORR = 3'b101;
   localparam logic [2:0] OP_BEQ = 3'b110;
   localparam logic [2:0] OP_B   = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_CMP   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   localparam logic [3:0] COND_UNDEF = 4'hF;

   typedef struct packed {
      logic       memReq;
      logic       memWe;
      logic       iord;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       regWrite;
      logic       memToReg;
   } ctrl_t;

   // Pure state decode of every control output that does not depend on an
   // input. The FSM registers this from the next state so the outputs come
   // straight from flops and line up with the state register.
   function automatic ctrl_t moore_decode(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.memReq  = 1'b1;
            c.aluSrcB = SRCB_FOUR;
            c.aluOp   = ALUOP_ADD;
            c.pcSrc   = PCSRC_ALU;
         end
         ST_DECODE: begin
            c.aluSrcB = SRCB_BROFF;
            c.aluOp   = ALUOP_ADD;
         end
         ST_EXEC_R: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_REGB;
            c.aluOp   = ALUOP_FUNCT;
         end
         ST_ALU_WB: begin
            c.regWrite = 1'b1;
         end
         ST_MEM_ADDR: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_IMM;
            c.aluOp   = ALUOP_ADD;
         end
         ST_MEM_RD: begin
            c.memReq = 1'b1;
            c.iord   = 1'b1;
         end
         ST_MEM_WB: begin
            c.regWrite = 1'b1;
            c.memToReg = 1'b1;
         end
         ST_MEM_WR: begin
            c.memReq = 1'b1;
            c.memWe  = 1'b1;
            c.iord   = 1'b1;
         end
         ST_BRANCH: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_REGB;
            c.aluOp   = ALUOP_CMP;
            c.pcSrc   = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            c.pcSrc = PCSRC_JUMP;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the unified memory port.
// Counts cycles where a request is outstanding without ready and flags a
// timeout once the count reaches TIMEOUT_CYCLES (0 disables the timeout).
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   active_i   a memory request is being presented this cycle
//   ready_i    memory completes the request this cycle
//   timeout_o  request abandoned this cycle (ready has priority)
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic active_i,
   input  logic ready_i,
   output logic timeout_o
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Timeout fires on the cycle the count has reached the limit and memory
   // still has not answered; a ready in that same cycle wins.
   assign timeout_o = (TIMEOUT_CYCLES != 0) && active_i && !ready_i &&
                      (count_q == 8'(TIMEOUT_CYCLES));

   // The count only survives across consecutive stalled request cycles.
   // Any completion, timeout or non-memory cycle returns it to zero, so every
   // fresh memory state starts counting from zero. It saturates so a disabled
   // timeout never wraps.
   always_comb begin
      count_d = '0;
      if (active_i && !ready_i && !timeout_o) begin
         count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle ARM-style core.
// Sequences fetch, decode, execute, memory and writeback, drives the ALUOp
// code and datapath selects/enables, and handles variable-latency memory
// with a req/ready handshake plus an optional wait-state timeout.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   instruction                IR contents
//   alu_zero, mem_ready        ALU zero flag, memory completion
//   mem_req, mem_we, iord      memory port control
//   ir_write, pc_write, pc_src IR/PC load and PC source
//   alu_src_a, alu_src_b, ALUOp ALU operand selects and operation class
//   reg_write, mem_to_reg      register file write control
//   illegal, bus_err           one-cycle error pulses
//   instr_count, state         retired count and debug state
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  ALUOp,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic        bus_err,
   output logic [31:0] instr_count,
   output logic [3:0]  state
);

   state_e      state_q;
   state_e      state_d;
   ctrl_t       ctrl_q;
   logic [31:0] instrCount_q;
   logic        retire;
   logic        timeout;
   logic [2:0]  opcode;
   logic [3:0]  cond;
   logic        unusedInstrBits;

   assign opcode          = instruction[27:25];
   assign cond            = instruction[31:28];
   assign unusedInstrBits = ^instruction[24:0];

   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .active_i  (ctrl_q.memReq),
      .ready_i   (mem_ready),
      .timeout_o (timeout)
   );

   // Next-state and retire decision. A timed-out memory access always falls
   // back to FETCH without retiring; a timed-out FETCH simply stays put and
   // retries the same PC because no PC write happened.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE:     state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (cond == COND_UNDEF) begin
               state_d = ST_FETCH;
            end else begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_ORR: state_d = ST_EXEC_R;
                  OP_LDR, OP_STR:                 state_d = ST_MEM_ADDR;
                  OP_BEQ:                         state_d = ST_BRANCH;
                  default:                        state_d = ST_JUMP;
               endcase
            end
         end
         ST_EXEC_R:   state_d = ST_ALU_WB;
         ST_ALU_WB: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_MEM_ADDR: state_d = (opcode == OP_LDR) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD: begin
            if (mem_ready)    state_d = ST_MEM_WB;
            else if (timeout) state_d = ST_FETCH;
         end
         ST_MEM_WB: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_MEM_WR: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end else if (timeout) begin
               state_d = ST_FETCH;
            end
         end
         ST_BRANCH, ST_JUMP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   // State register, registered Moore outputs and the retired-instruction
   // counter. The Moore outputs are loaded from the decode of the next state
   // so they are always consistent with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ctrl_q       <= '0;
         instrCount_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= moore_decode(state_d);
         if (retire) instrCount_q <= instrCount_q + 32'd1;
      end
   end

   // Output assembly. The request and write strobe are withdrawn in the
   // timeout cycle; IR/PC loads and the illegal pulse depend on inputs in
   // their states and so are gated combinationally here.
   always_comb begin
      mem_req     = ctrl_q.memReq & ~timeout;
      mem_we      = ctrl_q.memWe & ~timeout;
      iord        = ctrl_q.iord;
      pc_src      = ctrl_q.pcSrc;
      alu_src_a   = ctrl_q.aluSrcA;
      alu_src_b   = ctrl_q.aluSrcB;
      ALUOp       = ctrl_q.aluOp;
      reg_write   = ctrl_q.regWrite;
      mem_to_reg  = ctrl_q.memToReg;
      ir_write    = (state_q == ST_FETCH) && mem_ready;
      pc_write    = ((state_q == ST_FETCH) && mem_ready) ||
                    (state_q == ST_JUMP) ||
                    ((state_q == ST_BRANCH) && alu_zero);
      illegal     = (state_q == ST_DECODE) && (cond == COND_UNDEF);
      bus_err     = timeout;
      instr_count = instrCount_q;
      state       = state_q;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Walks directed and random instructions through the control FSM, building
// the expected per-cycle outputs from the instruction sequencing rules and
// the memory wait/timeout behaviour.
module tb_multicycle_control;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction;
   logic        alu_zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  ALUOp;
   logic        reg_write;
   logic        mem_to_reg;
   logic        illegal;
   logic        bus_err;
   logic [31:0] instr_count;
   logic [3:0]  state;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] expCount;

   multicycle_control #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instruction (instruction),
      .alu_zero    (alu_zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .iord        (iord),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .ALUOp       (ALUOp),
      .reg_write   (reg_write),
      .mem_to_reg  (mem_to_reg),
      .illegal     (illegal),
      .bus_err     (bus_err),
      .instr_count (instr_count),
      .state       (state)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] packOutputs();
      return {12'd0, state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
              alu_src_a, alu_src_b, ALUOp, reg_write, mem_to_reg, illegal, bus_err};
   endfunction

   // Randomise inputs that the current state must ignore.
   task automatic applyStimulus();
      mem_ready = 1'($urandom);
      alu_zero  = 1'($urandom);
   endtask

   // Called just after a falling edge with inputs already driven: checks all
   // outputs for this cycle plus the retire count, then moves one cycle on.
   task automatic stepCycle(input string tag, input logic [3:0] st,
                            input logic req, input logic we, input logic io,
                            input logic irw, input logic pcw, input logic [1:0] pcs,
                            input logic sa, input logic [1:0] sb, input logic [1:0] op,
                            input logic rw, input logic m2r, input logic ill, input logic berr);
      #1;
      checkOutput(tag, packOutputs(),
                  {12'd0, st, req, we, io, irw, pcw, pcs, sa, sb, op, rw, m2r, ill, berr});
      checkOutput({tag, ".count"}, instr_count, expCount);
      @(posedge clk);
      @(negedge clk);
   endtask

   // One memory access: memory answers after `waits` stalled cycles, unless
   // that exceeds the timeout limit, in which case the access is abandoned
   // on the (TO+1)-th request cycle.
   task automatic memPhase(input logic [3:0] st, input int waits, output bit done);
      logic       isFetch;
      logic       we;
      logic       io;
      logic [1:0] sb;
      isFetch = (st == 4'd1);
      we      = (st == 4'd8);
      io      = !isFetch;
      sb      = isFetch ? 2'b01 : 2'b00;
      done    = 1'b0;
      for (int c = 0; c <= TO; c++) begin
         mem_ready = (c == waits);
         alu_zero  = 1'($urandom);
         if (isFetch) instruction = $urandom;
         if (c == waits) begin
            stepCycle("memDone", st, 1'b1, we, io, isFetch, isFetch, 2'b00,
                      1'b0, sb, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            done = 1'b1;
            break;
         end else if (c == TO) begin
            stepCycle("memTimeout", st, 1'b0, 1'b0, io, 1'b0, 1'b0, 2'b00,
                      1'b0, sb, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
         end else begin
            stepCycle("memWait", st, 1'b1, we, io, 1'b0, 1'b0, 2'b00,
                      1'b0, sb, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   // Full instruction: fetch (retrying after timeouts), decode, then the
   // opcode-specific phases. Retire count follows the instruction outcome.
   task automatic runInstr(input logic [31:0] word, input int fWaits, input int mWaits, input logic zero);
      bit         done;
      int         w;
      int         tries;
      logic [2:0] opc;
      done  = 1'b0;
      w     = fWaits;
      tries = 0;
      opc   = word[27:25];
      while (!done) begin
         memPhase(4'd1, w, done);
         tries++;
         w = (tries > 8) ? 0 : $urandom_range(0, 6);
      end
      instruction = word;
      applyStimulus();
      stepCycle("decode", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b11, 2'b00, 1'b0, 1'b0, (word[31:28] == 4'hF), 1'b0);
      if (word[31:28] != 4'hF) begin
         case (opc)
            3'b000, 3'b010, 3'b100, 3'b101: begin
               applyStimulus();
               stepCycle("execR", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                         1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
               applyStimulus();
               stepCycle("aluWb", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                         1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
               expCount++;
            end
            3'b001, 3'b011: begin
               applyStimulus();
               stepCycle("memAddr", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                         1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
               memPhase((opc == 3'b001) ? 4'd6 : 4'd8, mWaits, done);
               if (done) begin
                  if (opc == 3'b001) begin
                     applyStimulus();
                     stepCycle("memWb", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
                  end
                  expCount++;
               end
            end
            3'b110: begin
               mem_ready = 1'($urandom);
               alu_zero  = zero;
               stepCycle("branch", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, zero, 2'b01,
                         1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
               expCount++;
            end
            default: begin
               applyStimulus();
               stepCycle("jump", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                         1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
               expCount++;
            end
         endcase
      end
   endtask

   // Directed sequences first, then a random instruction stream, then an
   // asynchronous reset in the middle of a load.
   initial begin
      bit          done;
      logic [31:0] word;
      rst_n       = 1'b0;
      instruction = '0;
      alu_zero    = 1'b0;
      mem_ready   = 1'b0;
      expCount    = '0;
      @(negedge clk);
      applyStimulus();
      stepCycle("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus();
      stepCycle("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      runInstr(32'hE000_0000, 0, 0, 1'b0);
      runInstr(32'hE200_0000, 0, 3, 1'b0);
      runInstr(32'hEC00_0000, 0, 0, 1'b1);
      runInstr(32'hEC00_0000, 0, 0, 1'b0);
      runInstr(32'hF000_0000, 0, 0, 1'b0);
      runInstr(32'hE000_0000, 5, 0, 1'b0);
      runInstr(32'hE000_0000, 4, 0, 1'b0);
      runInstr(32'hE600_0000, 0, 5, 1'b0);
      runInstr(32'hE600_0000, 1, 4, 1'b0);
      runInstr(32'hEE00_0000, 0, 0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         word = $urandom;
         runInstr(word, $urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom));
      end

      memPhase(4'd1, 0, done);
      instruction = 32'hE200_0000;
      applyStimulus();
      stepCycle("rstDecode", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      stepCycle("rstMemAddr", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      mem_ready = 1'b0;
      stepCycle("rstMemRd", 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n    = 1'b0;
      expCount = '0;
      stepCycle("midReset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus();
      stepCycle("postResetIdle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      runInstr(32'hE000_0000, 0, 0, 1'b0);
      runInstr(32'hEE00_0000, 2, 0, 1'b0);
      #1;
      checkOutput("finalCount", instr_count, expCount);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
